// File: rtl/radix4_approx_seq_mult.sv
// Iterative radix-4 (modified Booth) unsigned multiplier, one digit per clock, with per-operation
// exact/approximate mode. Define RADIX4_APPROX_COMP_EN to add truncation bias compensation.
module radix4_approx_seq_mult #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned APPROX_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 approx_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int unsigned D  = WIDTH / 2 + 1;
  localparam int unsigned TW = 2 * WIDTH + 3;
  localparam int unsigned CW = $clog2(D);
  localparam int unsigned PW = 2 * WIDTH;
  // Keeping only the upper columns of a two's-complement term floors it to a multiple of 2^k.
  localparam logic [TW-1:0] KeepMask = {TW{1'b1}} << APPROX_BITS;

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     mcand_q;
  logic [WIDTH+2:0]  bsh_q;
  logic [TW-1:0]     acc_q;
  logic [CW-1:0]     cnt_q;
  logic              approx_q;
  logic [PW-1:0]     p_q;

  logic [2:0]        code;
  logic [TW-1:0]     term;
  logic [TW-1:0]     term_m;
  logic [TW-1:0]     sum;
  logic [PW-1:0]     final_sum;
  logic              nz;
  logic              last;

  assign last = (cnt_q == CW'(D - 1));
  assign code = bsh_q[2:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (in_valid) state_d = StCompute;
      StCompute: if (last) state_d = StDone;
      StDone:    if (out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    out_valid = (state_q == StDone);
  end

  assign p = p_q;

  // Booth recoding of {b[2i+1], b[2i], b[2i-1]} into a signed multiple of the shifted multiplicand
  always_comb begin
    term = '0;
    nz   = 1'b1;
    case (code)
      3'b001, 3'b010: term = mcand_q;
      3'b011:         term = mcand_q << 1;
      3'b100:         term = -(mcand_q << 1);
      3'b101, 3'b110: term = -mcand_q;
      default: begin
        term = '0;
        nz   = 1'b0;
      end
    endcase
  end

  assign term_m = approx_q ? (term & KeepMask) : term;
  assign sum    = acc_q + term_m;

`ifdef RADIX4_APPROX_COMP_EN
  localparam int unsigned NW        = $clog2(D + 1);
  localparam int unsigned CompShift = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;

  logic [NW-1:0] nz_q;
  logic [NW-1:0] nz_total;
  logic [PW-1:0] comp;

  assign nz_total = nz_q + NW'(nz);
  assign comp     = (approx_q && (APPROX_BITS > 0)) ? (PW'(nz_total) << CompShift) : '0;
  assign final_sum = sum[PW-1:0] + comp;

  always_ff @(posedge clk) begin
    if (rst) begin
      nz_q <= '0;
    end else if (state_q == StIdle) begin
      nz_q <= '0;
    end else if (state_q == StCompute) begin
      nz_q <= nz_total;
    end
  end
`else
  assign final_sum = sum[PW-1:0];
`endif

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      bsh_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      approx_q <= 1'b0;
      p_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            mcand_q  <= TW'(a);
            bsh_q    <= {2'b00, b, 1'b0};
            acc_q    <= '0;
            cnt_q    <= '0;
            approx_q <= approx_en;
          end
        end
        StCompute: begin
          acc_q   <= sum;
          mcand_q <= mcand_q << 2;
          bsh_q   <= bsh_q >> 2;
          cnt_q   <= cnt_q + 1'b1;
          if (last) p_q <= final_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_approx_seq_mult.sv
// Directed and randomised self-checking bench for radix4_approx_seq_mult (WIDTH=16, APPROX_BITS=8).
module tb_radix4_approx_seq_mult;

  localparam int WIDTH = 16;
  localparam int AB    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              approx_en;
  logic              out_valid;
  logic              out_ready;
  logic [2*WIDTH-1:0] p;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;

  radix4_approx_seq_mult #(
    .WIDTH      (WIDTH),
    .APPROX_BITS(AB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .approx_en(approx_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p        (p),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Signed-arithmetic reference: sum of floor-truncated Booth terms
  function automatic logic [31:0] ref_mult(input logic [15:0] ma, input logic [15:0] mb,
                                           input logic m_approx);
    logic [18:0] bx;
    longint      sum;
    longint      t;
    int          d;
    int          nzc;
    logic [63:0] s;
    bx  = {2'b00, mb, 1'b0};
    sum = 0;
    nzc = 0;
    for (int i = 0; i < 9; i++) begin
      d = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
      t = longint'(d) * longint'(ma) * (longint'(1) << (2 * i));
      if (m_approx) t = (t >>> AB) <<< AB;
      if (d != 0) nzc++;
      sum += t;
    end
`ifdef RADIX4_APPROX_COMP_EN
    if (m_approx) sum += longint'(nzc) << (AB - 1);
`endif
    s = sum;
    return s[31:0];
  endfunction

  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_b, input logic tm);
    @(negedge clk);
    a         = ta;
    b         = tb_b;
    approx_en = tm;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; approx_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
    else n_pass++;
    n_checks++; if (p !== 32'd0) $display("FAIL reset_p got %0d want 0", p);
    else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_exact;
    int lat;
    start_op(16'd0, 16'd18, 1'b0);
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL compute_flags got busy=%b in_ready=%b want 1/0", busy, in_ready);
    else n_pass++;
    wait_out(lat);
    n_checks++; if (lat != 9) $display("FAIL latency got %0d want 9", lat);
    else n_pass++;
    n_checks++; if (p !== 32'd0) $display("FAIL exact_0x18 got %0d want 0", p);
    else n_pass++;
    consume();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL after_handshake got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    else n_pass++;
    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    wait_out(lat);
    n_checks++; if (out_valid !== 1'b1 || p !== 32'd4294836225)
      $display("FAIL exact_max got valid=%b p=%0d want 1/4294836225", out_valid, p);
    else n_pass++;
    consume();
  endtask

  task automatic test_approx;
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic        vm [4];
    logic [31:0] ve [4];
    int          lat;
    va = '{16'd1000, 16'd1000, 16'd255, 16'd32000};
    vb = '{16'd3, 16'd3, 16'd1, 16'd0};
    vm = '{1'b1, 1'b0, 1'b1, 1'b1};
`ifdef RADIX4_APPROX_COMP_EN
    ve = '{32'd3072, 32'd3000, 32'd128, 32'd0};
`else
    ve = '{32'd2816, 32'd3000, 32'd0, 32'd0};
`endif
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i], vm[i]);
      wait_out(lat);
      n_checks++;
      if (out_valid !== 1'b1 || p !== ve[i])
        $display("FAIL approx_vec%0d a=%0d b=%0d m=%b got valid=%b p=%0d want %0d",
                 i, va[i], vb[i], vm[i], out_valid, p, ve[i]);
      else n_pass++;
      consume();
    end
  endtask

  task automatic test_back_pressure;
    int lat;
    int idle_bad;
    start_op(16'd1234, 16'd5678, 1'b0);
    wait_out(lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = (k == 2);
      a = 16'd9;
      b = 16'd9;
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || p !== 32'd7006652 || in_ready !== 1'b0)
        $display("FAIL hold_cycle%0d got valid=%b p=%0d in_ready=%b want 1/7006652/0",
                 k, out_valid, p, in_ready);
      else n_pass++;
    end
    in_valid = 1'b0;
    consume();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 32'd7006652)
      $display("FAIL release got in_ready=%b valid=%b p=%0d want 1/0/7006652",
               in_ready, out_valid, p);
    else n_pass++;
    idle_bad = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0 || out_valid !== 1'b0) idle_bad++;
    end
    n_checks++; if (idle_bad != 0) $display("FAIL ignored_pulse got %0d busy cycles want 0", idle_bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int seen;
    start_op(16'd4321, 16'd8765, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || p !== 32'd0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL mid_reset got valid=%b p=%0d in_ready=%b busy=%b want 0/0/1/0",
               out_valid, p, in_ready, busy);
    else n_pass++;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) seen++;
    end
    n_checks++; if (seen != 0) $display("FAIL stale_result got %0d valid cycles want 0", seen);
    else n_pass++;
  endtask

  task automatic test_mode_isolation;
    int lat;
    start_op(16'd12345, 16'd54321, 1'b0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      approx_en = ~approx_en;
      a = ~a;
      @(posedge clk);
      #1;
      lat++;
    end
    n_checks++; if (lat != 9 || p !== 32'd670592745)
      $display("FAIL mode_isolation got lat=%0d p=%0d want 9/670592745", lat, p);
    else n_pass++;
    consume();
  endtask

  task automatic test_random;
    int          lat;
    int          bad;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rm;
    logic [31:0] exp_p;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rm = 1'($urandom_range(0, 1));
      exp_p = ref_mult(ra, rb, rm);
      start_op(ra, rb, rm);
      wait_out(lat);
      n_checks++;
      if (out_valid !== 1'b1 || p !== exp_p) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random%0d a=%0d b=%0d m=%b got valid=%b p=%0d want %0d",
                   i, ra, rb, rm, out_valid, p, exp_p);
      end else n_pass++;
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_approx();
    test_back_pressure();
    test_reset_mid();
    test_mode_isolation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
